// File: rtl/keypad_event_fifo.sv
// rtl/keypad_event_fifo.sv - 4x4 keypad frame resolver, debouncer and key event FIFO (optional KEYPAD_REPEAT_EN auto-repeat)
module keypad_event_fifo #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sel,
  input  logic [3:0] col_in,
  output logic [3:0] ev_key,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       key_held,
  output logic       ghost,
  output logic       overflow
);

  localparam int CNT_W = (DEBOUNCE_FRAMES > 2) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_KEY   = 2'd1;
  localparam logic [1:0] KIND_MULTI = 2'd2;

  typedef enum logic {ST_IDLE, ST_PRESSED} state_t;

  // Sample decode
  logic       w_row_valid;
  logic       w_col_one;
  logic       w_col_multi;
  logic [1:0] w_row_idx;
  logic [1:0] w_col_idx;

  // Frame accumulator
  logic       r_in_frame;
  logic [1:0] r_acc_kind;
  logic [3:0] r_acc_key;
  logic [1:0] w_base_kind;
  logic [3:0] w_base_key;
  logic [1:0] w_res_kind;
  logic [3:0] w_res_key;
  logic       w_close;

  // Debounce
  logic [1:0]       r_prev_kind;
  logic [3:0]       r_prev_key;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_same;
  logic             w_qualify;
  logic             r_ghost;

  // FSM
  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cur_key;
  logic [3:0] w_key_next;
  logic       w_fsm_push;
  logic       w_rep_push;
  logic       w_state_change;

  // FIFO
  logic [3:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic         r_overflow;

  assign w_row_valid = $onehot(~row_sel);
  assign w_col_one   = $onehot(~col_in);
  assign w_col_multi = (col_in != 4'hF) && !w_col_one;

  // Row and column index from the active-low one-hot codes (row0/col0 is the MSB)
  always_comb begin
    w_row_idx = 2'd0;
    w_col_idx = 2'd0;
    case (row_sel)
      4'b0111: w_row_idx = 2'd0;
      4'b1011: w_row_idx = 2'd1;
      4'b1101: w_row_idx = 2'd2;
      4'b1110: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
    case (col_in)
      4'b0111: w_col_idx = 2'd0;
      4'b1011: w_col_idx = 2'd1;
      4'b1101: w_col_idx = 2'd2;
      4'b1110: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Frame result including the current sample; row0 always starts from an empty frame
  always_comb begin
    w_base_kind = (w_row_idx == 2'd0) ? KIND_NONE : r_acc_kind;
    w_base_key  = (w_row_idx == 2'd0) ? 4'd0 : r_acc_key;
    w_res_kind  = w_base_kind;
    w_res_key   = w_base_key;
    if (w_col_multi) begin
      w_res_kind = KIND_MULTI;
    end else if (w_col_one) begin
      if (w_base_kind == KIND_NONE) begin
        w_res_kind = KIND_KEY;
        w_res_key  = {w_row_idx, w_col_idx};
      end else begin
        w_res_kind = KIND_MULTI;
      end
    end
  end

  // A frame only closes if its row0 was seen, so a partial frame after reset is discarded
  assign w_close = w_row_valid && (w_row_idx == 2'd3) && r_in_frame;

  // Frame accumulator update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_frame <= 1'b0;
      r_acc_kind <= KIND_NONE;
      r_acc_key  <= 4'd0;
    end else if (w_row_valid) begin
      if (w_row_idx == 2'd0) begin
        r_in_frame <= 1'b1;
        r_acc_kind <= w_res_kind;
        r_acc_key  <= w_res_key;
      end else if (r_in_frame) begin
        if (w_row_idx == 2'd3) begin
          r_in_frame <= 1'b0;
          r_acc_kind <= KIND_NONE;
          r_acc_key  <= 4'd0;
        end else begin
          r_acc_kind <= w_res_kind;
          r_acc_key  <= w_res_key;
        end
      end
    end
  end

  assign w_same     = (w_res_kind == r_prev_kind) &&
                      ((w_res_kind != KIND_KEY) || (w_res_key == r_prev_key));
  assign w_cnt_next = !w_same ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
  assign w_qualify  = w_close && (w_cnt_next == CNT_MAX) && (w_res_kind != KIND_MULTI);

  // Debounce history and ghost flag, updated once per closed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_kind <= KIND_NONE;
      r_prev_key  <= 4'd0;
      r_cnt       <= '0;
      r_ghost     <= 1'b0;
    end else if (w_close) begin
      r_prev_kind <= w_res_kind;
      r_prev_key  <= w_res_key;
      r_cnt       <= w_cnt_next;
      r_ghost     <= (w_res_kind == KIND_MULTI);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur_key <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_cur_key <= w_key_next;
    end
  end

  // FSM next state and press/rollover push, driven only by qualifying results
  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_cur_key;
    w_fsm_push   = 1'b0;
    if (w_qualify) begin
      case (r_state)
        ST_IDLE: begin
          if (w_res_kind == KIND_KEY) begin
            w_state_next = ST_PRESSED;
            w_key_next   = w_res_key;
            w_fsm_push   = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (w_res_kind == KIND_NONE) begin
            w_state_next = ST_IDLE;
          end else if (w_res_key != r_cur_key) begin
            w_key_next = w_res_key;
            w_fsm_push = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_state_change = (w_state_next != r_state) || (w_key_next != r_cur_key);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD_V = REP_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_inc;
  logic             w_rep_hold;

  assign w_rep_inc  = r_rep_cnt + 1'b1;
  assign w_rep_hold = (r_state == ST_PRESSED) && !w_state_change &&
                      (w_res_kind == KIND_KEY) && (w_res_key == r_cur_key);
  assign w_rep_push = w_close && w_rep_hold && (w_rep_inc == REP_DELAY_V);

  // Held-frame counter; reloading to DELAY-RATE makes later repeats come every RATE frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if (w_close) begin
      if (!w_rep_hold)
        r_rep_cnt <= '0;
      else if (w_rep_inc == REP_DELAY_V)
        r_rep_cnt <= REP_RELOAD_V;
      else
        r_rep_cnt <= w_rep_inc;
    end
  end
`else
  assign w_rep_push = 1'b0;
`endif

  assign w_push  = w_fsm_push || w_rep_push;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && ev_ready;

  // Event FIFO; a push into a full FIFO only succeeds when the head leaves on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 4'd0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_push && (!w_full || w_pop)) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= w_fsm_push ? w_key_next : r_cur_key;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign ev_valid = !w_empty;
  assign ev_key   = w_empty ? 4'd0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign key_held = (r_state == ST_PRESSED);
  assign ghost    = r_ghost;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// tb/tb_keypad_event_fifo.sv - directed bench for keypad_event_fifo
module tb_keypad_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_sel = 4'hF;
  logic [3:0] col_in = 4'hF;
  logic [3:0] ev_key;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic       key_held;
  logic       ghost;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  keypad_event_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .row_sel  (row_sel),
    .col_in   (col_in),
    .ev_key   (ev_key),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .key_held (key_held),
    .ghost    (ghost),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] c);
    row_sel = r;
    col_in  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_key(input int k);
    logic [3:0] one;
    logic [3:0] rs;
    logic [3:0] cs;
    one = 4'b1000;
    for (int rr = 0; rr < 4; rr++) begin
      rs = ~(one >> rr);
      cs = 4'hF;
      if (k >= 0 && (k / 4) == rr) cs = ~(one >> (k % 4));
      cyc(rs, cs);
    end
  endtask

  task automatic frames(input int k, input int n);
    for (int i = 0; i < n; i++) frame_key(k);
  endtask

  task automatic pop_one;
    ev_ready = 1'b1;
    cyc(4'hF, 4'hF);
    ev_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_push;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", ev_valid, 0);
    chk("reset_key", ev_key, 0);
    chk("reset_held", key_held, 0);
    chk("reset_ghost", ghost, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1'b0;
    cyc(4'hF, 4'hF);

    // 1: key 5, qualifies on the 4th identical frame
    frames(5, 3);
    chk("k5_not_yet", ev_valid, 0);
    frame_key(5);
    chk("k5_valid", ev_valid, 1);
    chk("k5_key", ev_key, 5);
    chk("k5_held", key_held, 1);
    pop_one();
    chk("k5_popped", ev_valid, 0);

    // release: 4 NONE frames
    frames(-1, 3);
    chk("rel_held_3", key_held, 1);
    frame_key(-1);
    chk("rel_held_4", key_held, 0);
    chk("rel_no_event", ev_valid, 0);

    // 2: bounce
    for (int i = 0; i < 10; i++) frame_key((i % 2 == 0) ? 5 : -1);
    chk("bounce_valid", ev_valid, 0);
    chk("bounce_held", key_held, 0);

    // 3: key 15
    frames(15, 4);
    chk("k15_valid", ev_valid, 1);
    chk("k15_key", ev_key, 15);
    chk("k15_held", key_held, 1);
    pop_one();

    // 4: overflow with rollover presses
    frames(1, 4);
    frames(2, 4);
    frames(3, 4);
    frames(4, 4);
    chk("full_no_ovf", overflow, 0);
    frames(6, 4);
    chk("ovf_pulse", overflow, 1);
    cyc(4'hF, 4'hF);
    chk("ovf_one_cycle", overflow, 0);
    chk("ovf_head1", ev_key, 1);
    pop_one();
    chk("ovf_head2", ev_key, 2);
    pop_one();
    chk("ovf_head3", ev_key, 3);
    pop_one();
    chk("ovf_head4", ev_key, 4);
    pop_one();
    chk("ovf_drained", ev_valid, 0);
    pop_one();
    chk("pop_empty", ev_valid, 0);

    // 5: ghost
    cyc(4'b0111, 4'b0011);
    cyc(4'b1011, 4'hF);
    cyc(4'b1101, 4'hF);
    cyc(4'b1110, 4'hF);
    chk("ghost_set", ghost, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0111, 4'b0011);
      cyc(4'b1011, 4'hF);
      cyc(4'b1101, 4'hF);
      cyc(4'b1110, 4'hF);
    end
    chk("ghost_no_event", ev_valid, 0);
    chk("ghost_held_prev", key_held, 1);
    frame_key(15);
    cyc(4'b0111, 4'hF);
    cyc(4'b1011, 4'hF);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_ghost", ghost, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b1101, 4'hF);
    cyc(4'b1110, 4'b1110);
    frames(15, 3);
    chk("partial_discard", ev_valid, 0);
    frame_key(15);
    chk("post_rst_valid", ev_valid, 1);
    chk("post_rst_key", ev_key, 15);
    pop_one();

    // 6: hold key 0 for 4+32+16 frames
    for (int f = 1; f <= 52; f++) begin
      frame_key(0);
`ifdef KEYPAD_REPEAT_EN
      exp_push = (f == 4 || f == 36 || f == 44 || f == 52) ? 1 : 0;
`else
      exp_push = (f == 4) ? 1 : 0;
`endif
      chk($sformatf("hold_f%0d_valid", f), ev_valid, 8'(exp_push));
      if (ev_valid) begin
        chk($sformatf("hold_f%0d_key", f), ev_key, 0);
        pop_one();
      end
    end
    chk("hold_held", key_held, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
